// File: rtl/nco_sweep_pkg.sv
// Shared encodings for the NCO frequency-sweep sequencer.
package nco_sweep_pkg;

  localparam int FTW_W_DEF = 28;

  localparam logic [1:0] MODE_SINGLE   = 2'd0;
  localparam logic [1:0] MODE_REPEAT   = 2'd1;
  localparam logic [1:0] MODE_TRIANGLE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_ENDPT = 2'd2
  } state_t;

endpackage

// File: rtl/nco_sweep_step.sv
// One sweep step toward a stop FTW: saturating add/sub that clamps at stop.
module nco_sweep_step
  import nco_sweep_pkg::*;
#(
  parameter int FTW_W = FTW_W_DEF
) (
  input  logic [FTW_W-1:0] cur,
  input  logic [FTW_W-1:0] step,
  input  logic [FTW_W-1:0] stop,
  input  logic             dir_up,
  output logic [FTW_W-1:0] nxt,
  output logic             at_end
);

  logic [FTW_W:0] sum;
  logic [FTW_W:0] diff;

  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    // Carry-out / borrow-out means we ran past the stop value as well.
    if (dir_up) at_end = (sum >= {1'b0, stop});
    else        at_end = diff[FTW_W] || (diff[FTW_W-1:0] <= stop);
    if (at_end)      nxt = stop;
    else if (dir_up) nxt = sum[FTW_W-1:0];
    else             nxt = diff[FTW_W-1:0];
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear chirp sequencer driving the phase_acc tuning word (single/repeat/triangle).
// Define NCO_SWEEP_COUNT_EN to add the saturating sweep_count pass counter output.
module nco_sweep_ctrl
  import nco_sweep_pkg::*;
#(
  parameter int FTW_W   = FTW_W_DEF,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FTW_W-1:0]   ftw_start,
  input  logic [FTW_W-1:0]   ftw_stop,
  input  logic [FTW_W-1:0]   ftw_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   nco_set,
  output logic               busy,
`ifdef NCO_SWEEP_COUNT_EN
  output logic [15:0]        sweep_count,
`endif
  output logic               done
);

  state_t               state, state_nxt;
  logic [FTW_W-1:0]     sh_start, sh_stop, sh_step;
  logic [FTW_W-1:0]     sh_start_nxt, sh_stop_nxt, sh_step_nxt;
  logic [DWELL_W-1:0]   sh_dwell, sh_dwell_nxt, cnt, cnt_nxt;
  logic [1:0]           sh_mode, sh_mode_nxt;
  logic                 dir_up, dir_up_nxt, degen, degen_nxt;
  logic [FTW_W-1:0]     nco_nxt;
  logic                 busy_nxt, done_nxt;
  logic                 accept, endpt_fin;
  logic                 turn;
  logic [FTW_W-1:0]     step_nxt;
  logic                 step_at_end;

  // At a triangle turnaround the step is taken toward the old start, so the
  // endpoint value is not emitted twice.
  assign turn = (state == ST_ENDPT);

  nco_sweep_step #(.FTW_W(FTW_W)) u_step (
    .cur    (nco_set),
    .step   (sh_step),
    .stop   (turn ? sh_start : sh_stop),
    .dir_up (turn ? ~dir_up : dir_up),
    .nxt    (step_nxt),
    .at_end (step_at_end)
  );

  always_comb begin
    state_nxt    = state;
    sh_start_nxt = sh_start;
    sh_stop_nxt  = sh_stop;
    sh_step_nxt  = sh_step;
    sh_dwell_nxt = sh_dwell;
    sh_mode_nxt  = sh_mode;
    dir_up_nxt   = dir_up;
    degen_nxt    = degen;
    cnt_nxt      = cnt;
    nco_nxt      = nco_set;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    accept       = 1'b0;
    endpt_fin    = 1'b0;
    if (state != ST_IDLE && abort) begin
      state_nxt = ST_IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            accept       = 1'b1;
            sh_start_nxt = ftw_start;
            sh_stop_nxt  = ftw_stop;
            sh_step_nxt  = ftw_step;
            sh_dwell_nxt = dwell;
            sh_mode_nxt  = mode;
            dir_up_nxt   = (ftw_stop >= ftw_start);
            degen_nxt    = (ftw_start == ftw_stop) || (ftw_step == '0);
            nco_nxt      = ftw_start;
            busy_nxt     = 1'b1;
            cnt_nxt      = dwell;
            state_nxt    = ((ftw_start == ftw_stop) || (ftw_step == '0)) ? ST_ENDPT : ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - DWELL_W'(1);
          end else begin
            nco_nxt = step_nxt;
            cnt_nxt = sh_dwell;
            if (step_at_end) state_nxt = ST_ENDPT;
          end
        end
        ST_ENDPT: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - DWELL_W'(1);
          end else begin
            endpt_fin = 1'b1;
            cnt_nxt   = sh_dwell;
            case (sh_mode)
              MODE_REPEAT: begin
                nco_nxt   = sh_start;
                state_nxt = degen ? ST_ENDPT : ST_DWELL;
              end
              MODE_TRIANGLE: begin
                sh_start_nxt = sh_stop;
                sh_stop_nxt  = sh_start;
                dir_up_nxt   = ~dir_up;
                nco_nxt      = step_nxt;
                state_nxt    = (step_at_end || degen) ? ST_ENDPT : ST_DWELL;
              end
              default: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
              end
            endcase
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
      sh_mode  <= '0;
      dir_up   <= 1'b0;
      degen    <= 1'b0;
      cnt      <= '0;
      nco_set  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sh_start <= sh_start_nxt;
      sh_stop  <= sh_stop_nxt;
      sh_step  <= sh_step_nxt;
      sh_dwell <= sh_dwell_nxt;
      sh_mode  <= sh_mode_nxt;
      dir_up   <= dir_up_nxt;
      degen    <= degen_nxt;
      cnt      <= cnt_nxt;
      nco_set  <= nco_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

`ifdef NCO_SWEEP_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)                                sweep_count <= '0;
    else if (accept)                          sweep_count <= '0;
    else if (endpt_fin && sweep_count != '1)  sweep_count <= sweep_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed bench for nco_sweep_ctrl with a per-cycle expected-output scoreboard.
module tb_nco_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic [27:0] ftw_start, ftw_stop, ftw_step;
  logic [15:0] dwell;
  logic [27:0] nco_set;
  logic        busy;
  logic        done;
`ifdef NCO_SWEEP_COUNT_EN
  logic [15:0] sweep_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [27:0] nco;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t q[$];

  nco_sweep_ctrl #(.FTW_W(28), .DWELL_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .ftw_start (ftw_start),
    .ftw_stop  (ftw_stop),
    .ftw_step  (ftw_step),
    .dwell     (dwell),
    .nco_set   (nco_set),
    .busy      (busy),
`ifdef NCO_SWEEP_COUNT_EN
    .sweep_count (sweep_count),
`endif
    .done      (done)
  );

  always #5 clock = ~clock;

  // Advance one edge; start/abort are single-cycle pulses.
  task automatic tick();
    @(posedge clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic push(input logic [27:0] v, input int n, input logic b, input logic d);
    for (int i = 0; i < n; i++) q.push_back(exp_t'({v, b, d}));
  endtask

  task automatic load(input logic [27:0] s, input logic [27:0] e, input logic [27:0] st,
                      input logic [15:0] dw, input logic [1:0] m);
    ftw_start = s;
    ftw_stop  = e;
    ftw_step  = st;
    dwell     = dw;
    mode      = m;
  endtask

  task automatic do_start(input logic [27:0] s, input logic [27:0] e, input logic [27:0] st,
                          input logic [15:0] dw, input logic [1:0] m);
    load(s, e, st, dw, m);
    start = 1'b1;
    tick();
  endtask

  task automatic check_q(input string tag);
    exp_t e;
    int   idx;
    idx = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      assert ({nco_set, busy, done} === {e.nco, e.busy, e.done}) else begin
        errors++;
        $error("FAIL %s[%0d] got nco=%h busy=%b done=%b expected nco=%h busy=%b done=%b",
               tag, idx, nco_set, busy, done, e.nco, e.busy, e.done);
      end
      idx++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    abort = 1'b0;
    load(28'h123, 28'h456, 28'h10, 16'd0, 2'd0);
    start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    push(28'h0, 1, 1'b0, 1'b0);
    check_q("reset_held");
    reset = 1'b0;
    start = 1'b0;
    push(28'h0, 2, 1'b0, 1'b0);
    check_q("reset_release");

    // Single sweep upward, dwell 1
    do_start(28'h100, 28'h400, 28'h100, 16'd1, 2'd0);
    push(28'h100, 2, 1'b1, 1'b0);
    push(28'h200, 2, 1'b1, 1'b0);
    push(28'h300, 2, 1'b1, 1'b0);
    push(28'h400, 2, 1'b1, 1'b0);
    push(28'h400, 1, 1'b0, 1'b1);
    push(28'h400, 1, 1'b0, 1'b0);
    check_q("single_up");

    // Clamp near the top of the FTW range: no wrap-around
    do_start(28'hFFFFF00, 28'hFFFFFFF, 28'h80, 16'd0, 2'd0);
    push(28'hFFFFF00, 1, 1'b1, 1'b0);
    push(28'hFFFFF80, 1, 1'b1, 1'b0);
    push(28'hFFFFFFF, 1, 1'b1, 1'b0);
    push(28'hFFFFFFF, 1, 1'b0, 1'b1);
    push(28'hFFFFFFF, 1, 1'b0, 1'b0);
    check_q("clamp_top");

    // Partial last step clamps to stop; reserved mode behaves as single
    do_start(28'h100, 28'h350, 28'h100, 16'd0, 2'd3);
    push(28'h100, 1, 1'b1, 1'b0);
    push(28'h200, 1, 1'b1, 1'b0);
    push(28'h300, 1, 1'b1, 1'b0);
    push(28'h350, 1, 1'b1, 1'b0);
    push(28'h350, 1, 1'b0, 1'b1);
    push(28'h350, 1, 1'b0, 1'b0);
    check_q("clamp_partial");

    // Triangle: endpoints emitted once per turn, then abort freezes nco_set
    do_start(28'h10, 28'h30, 28'h10, 16'd0, 2'd2);
    push(28'h10, 1, 1'b1, 1'b0);
    push(28'h20, 1, 1'b1, 1'b0);
    push(28'h30, 1, 1'b1, 1'b0);
    push(28'h20, 1, 1'b1, 1'b0);
    push(28'h10, 1, 1'b1, 1'b0);
    push(28'h20, 1, 1'b1, 1'b0);
    push(28'h30, 1, 1'b1, 1'b0);
    push(28'h20, 1, 1'b1, 1'b0);
    check_q("triangle");
    abort = 1'b1;
    tick();
    push(28'h10, 3, 1'b0, 1'b0);
    check_q("triangle_abort");

    // Downward repeat, dwell 2; a start pulse mid-sweep is ignored
    do_start(28'h40, 28'h10, 28'h18, 16'd2, 2'd1);
    push(28'h40, 3, 1'b1, 1'b0);
    push(28'h28, 2, 1'b1, 1'b0);
    check_q("repeat_down");
    load(28'h999, 28'hAAA, 28'h1, 16'd0, 2'd0);
    start = 1'b1;
    push(28'h28, 1, 1'b1, 1'b0);
    push(28'h10, 3, 1'b1, 1'b0);
    push(28'h40, 3, 1'b1, 1'b0);
    push(28'h28, 3, 1'b1, 1'b0);
    push(28'h10, 1, 1'b1, 1'b0);
    check_q("repeat_ignore_start");
    abort = 1'b1;
    tick();
    push(28'h10, 2, 1'b0, 1'b0);
    check_q("repeat_abort");

    // Start and abort together from idle: abort wins
    load(28'h77, 28'h99, 28'h1, 16'd0, 2'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    push(28'h10, 2, 1'b0, 1'b0);
    check_q("start_abort");

    // Zero step: start value dwells dwell+1 clocks, then done
    do_start(28'h55, 28'h100, 28'h0, 16'd3, 2'd0);
    push(28'h55, 4, 1'b1, 1'b0);
    push(28'h55, 1, 1'b0, 1'b1);
    push(28'h55, 1, 1'b0, 1'b0);
    check_q("zero_step");

`ifdef NCO_SWEEP_COUNT_EN
    do_start(28'h10, 28'h30, 28'h10, 16'd0, 2'd1);
    checks++;
    assert (sweep_count === 16'd0) else begin
      errors++;
      $error("FAIL count_clear got %0d expected 0", sweep_count);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    assert ({nco_set, sweep_count} === {28'h10, 16'd3}) else begin
      errors++;
      $error("FAIL count_3pass got nco=%h count=%0d expected nco=10 count=3", nco_set, sweep_count);
    end
    abort = 1'b1;
    tick();
    tick();
    checks++;
    assert ({busy, sweep_count} === {1'b0, 16'd3}) else begin
      errors++;
      $error("FAIL count_abort got busy=%b count=%0d expected busy=0 count=3", busy, sweep_count);
    end
`endif

    // Reset mid-sweep returns everything to zero
    do_start(28'h200, 28'h100, 28'h10, 16'd4, 2'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push(28'h0, 2, 1'b0, 1'b0);
    check_q("reset_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
